// File: rtl/n2t_pkg.sv
// ============================================================================
// Module      : n2t_pkg
// Description : Shared types and constants for the chapter-03 storage blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package n2t_pkg;

   localparam int WORD_W = 16;

   // Shared with the matching deserializer, so keep the encoding stable.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   function automatic logic ser_parity(input logic [WORD_W-1:0] word);
      return ^word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/counter_n2t.sv
// ============================================================================
// Module      : counter_n2t
// Description : Up-counter with synchronous clear (priority) and increment
//               enable. Also used by the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_n2t #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/reg_serializer_n2t.sv
// ============================================================================
// Module      : reg_serializer_n2t
// Description : Captures a WIDTH-bit word on a load strobe and sends it one
//               bit per valid/ready transfer. Define SER_PARITY_EN to append
//               an even-parity bit after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_serializer_n2t
   import n2t_pkg::*;
#(
   parameter int WIDTH     = WORD_W,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_in,
   input  logic             i_load,
   output logic             o_out,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_done
);

   localparam int               CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       r_state;
   logic [WIDTH-1:0] r_shift;
   logic             r_out;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
`ifdef SER_PARITY_EN
   logic             r_parity;
`endif

   logic [CNT_W-1:0] w_count;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_xfer;
   logic             w_load_acc;
   logic             w_last_xfer;
   logic             w_bit_inc;

   function automatic logic f_lead_bit(input logic [WIDTH-1:0] word);
      return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
   endfunction

   // The bit on the wire is always the leading end of the shift register.
   assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shift[WIDTH-1:1]};

   assign w_xfer      = r_valid & i_out_ready;
   assign w_load_acc  = (r_state == IDLE) & i_load;
   assign w_last_xfer = (r_state == SHIFT) & w_xfer & (w_count == c_LAST);
   assign w_bit_inc   = (r_state == SHIFT) & w_xfer & (w_count != c_LAST);

   counter_n2t #(
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_load_acc | w_last_xfer),
      .i_inc   (w_bit_inc),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_out    <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SER_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_load) begin
                  r_shift  <= i_in;
                  r_out    <= f_lead_bit(i_in);
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
`ifdef SER_PARITY_EN
                  r_parity <= ser_parity(WORD_W'(i_in));
`endif
               end
            end
            SHIFT: begin
               if (w_xfer) begin
                  if (w_count == c_LAST) begin
`ifdef SER_PARITY_EN
                     r_out   <= r_parity;
                     r_state <= PARITY;
`else
                     r_out   <= 1'b0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
`endif
                  end else begin
                     r_shift <= w_shift_nxt;
                     r_out   <= f_lead_bit(w_shift_nxt);
                  end
               end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
               if (w_xfer) begin
                  r_out   <= 1'b0;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
`endif
            default: begin
               r_out   <= 1'b0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_out       = r_out;
   assign o_out_valid = r_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_serializer_n2t.sv
// ============================================================================
// Module      : tb_reg_serializer_n2t
// Description : Self-checking bench for reg_serializer_n2t (MSB- and LSB-first
//               instances) against a queue-based model of the bit stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_serializer_n2t;

   localparam int W = 16;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         load  = 1'b0;
   logic         ready = 1'b0;
   logic [W-1:0] din   = '0;

   logic out1, v1, b1, d1;
   logic out0, v0, b0, d0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Bits still to be sent, in wire order, for each instance.
   bit q1[$];
   bit q0[$];
   bit m_done = 1'b0;

   logic [W-1:0] c_a5 = 16'hA5C3;

   always #5 clk = ~clk;

   reg_serializer_n2t #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .reset(reset), .i_in(din), .i_load(load),
      .o_out(out1), .o_out_valid(v1), .i_out_ready(ready),
      .o_busy(b1), .o_done(d1)
   );

   reg_serializer_n2t #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset(reset), .i_in(din), .i_load(load),
      .o_out(out0), .o_out_valid(v0), .i_out_ready(ready),
      .o_busy(b0), .o_done(d0)
   );

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         q1.delete();
         q0.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (q1.size() != 0) begin
            if (ready) begin
               void'(q1.pop_front());
               void'(q0.pop_front());
               if (q1.size() == 0) m_done = 1'b1;
            end
         end else if (load) begin
            for (int i = W - 1; i >= 0; i--) q1.push_back(din[i]);
            for (int i = 0; i < W; i++)      q0.push_back(din[i]);
`ifdef SER_PARITY_EN
            q1.push_back(^din);
            q0.push_back(^din);
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("msb_out",   out1, (q1.size() != 0) ? q1[0] : 1'b0);
         check("msb_valid", v1,   q1.size() != 0);
         check("msb_busy",  b1,   q1.size() != 0);
         check("msb_done",  d1,   m_done);
         check("lsb_out",   out0, (q0.size() != 0) ? q0[0] : 1'b0);
         check("lsb_valid", v0,   q0.size() != 0);
         check("lsb_busy",  b0,   q0.size() != 0);
         check("lsb_done",  d0,   m_done);
      end
   end

   initial begin
      reset = 1'b1;
      repeat (2) step();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_out",   out1, 1'b0);
      check("rst_valid", v1,   1'b0);
      check("rst_busy",  b1,   1'b0);
      check("rst_done",  d1,   1'b0);
      reset = 1'b0;
      step();

      // Plain word, consumer always ready.
      din = c_a5; load = 1'b1; ready = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         check("lit_msb_bit", out1, c_a5[W-1-k]);
         if (k < 8) check("lit_lsb_bit", out0, c_a5[k]);
         check("lit_no_done", d1, 1'b0);
         step();
      end
`ifdef SER_PARITY_EN
      @(negedge clk);
      check("lit_parity", out1, 1'b0);
      step();
`endif
      @(negedge clk);
      check("lit_done_msb", d1, 1'b1);
      check("lit_done_lsb", d0, 1'b1);
      step();
      @(negedge clk);
      check("lit_done_gone", d1, 1'b0);
      step();

      // Backpressure in cycles 3-6, with an ignored load at cycle 5.
      din = c_a5; load = 1'b1; ready = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      ready = 1'b0;
      for (int k = 3; k <= 6; k++) begin
         if (k == 5) begin
            din  = 16'hFFFF;
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
         check("lit_stall_bit",   out1, c_a5[W-3]);
         check("lit_stall_valid", v1,   1'b1);
         step();
      end
      load  = 1'b0;
      ready = 1'b1;
`ifdef SER_PARITY_EN
      repeat (15) step();
`else
      repeat (14) step();
`endif
      @(negedge clk);
      check("lit_late_done", d1, 1'b1);
      step();

      // Reset in the middle of a word, then a fresh word.
      din = c_a5; load = 1'b1;
      step();
      load = 1'b0;
      repeat (7) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("lit_abort_busy",  b1,   1'b0);
      check("lit_abort_valid", v1,   1'b0);
      check("lit_abort_out",   out1, 1'b0);
      check("lit_abort_done",  d1,   1'b0);
      din = 16'h0001; load = 1'b1;
      step();
      load = 1'b0;
      repeat (20) step();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         load  = ($urandom_range(0, 3) == 0);
         din   = W'($urandom);
         ready = ($urandom_range(0, 9) < 7);
         step();
      end
      reset = 1'b0;
      load  = 1'b0;
      ready = 1'b1;
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
